// File: rtl/oil_paint_pkg.sv
`default_nettype none
// ============================================================================
// Module      : oil_paint_pkg
// Description : Shared types and helpers for the oil-painting stream filter.
// Revision    : 1.0 - initial release
// ============================================================================
package oil_paint_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_QUANT  = 2'd1,
        MODE_OIL    = 2'd2
    } mode_e;

    // 2x2 ordered-dither thresholds indexed by {line_parity, x[0]}
    localparam logic [1:0] c_bayer [4] = '{2'd0, 2'd2, 2'd3, 2'd1};

    function automatic mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'd0:    return MODE_BYPASS;
            2'd1:    return MODE_QUANT;
            default: return MODE_OIL;
        endcase
    endfunction

    // Intensity bin: top lvl_w bits of (r + 2g + b), a ch_w+2 bit sum
    function automatic logic [7:0] calc_bin(input logic [15:0] q_r,
                                            input logic [15:0] q_g,
                                            input logic [15:0] q_b,
                                            input int          ch_w,
                                            input int          lvl_w);
        logic [17:0] sum;
        sum = {2'b00, q_r} + {1'b0, q_g, 1'b0} + {2'b00, q_b};
        return 8'(sum >> (ch_w + 2 - lvl_w));
    endfunction

endpackage
`default_nettype wire

// File: rtl/oil_paint_hist.sv
`default_nettype none
// ============================================================================
// Module      : oil_paint_hist
// Description : Window histogram, dominant-bin argmax (ties to lowest bin) and
//               newest-matching-entry select. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module oil_paint_hist #(
    parameter  int WIN   = 5,
    parameter  int LVL_W = 3,
    localparam int IDX_W = $clog2(WIN)
) (
    input  logic [LVL_W-1:0] i_bins [WIN],
    input  logic [WIN-1:0]   i_vld,
    output logic [LVL_W-1:0] o_bin,
    output logic [IDX_W-1:0] o_sel
);
    localparam int NB    = 2 ** LVL_W;
    localparam int CNT_W = $clog2(WIN + 1);

    logic [CNT_W-1:0] w_cnt [NB];
    logic [CNT_W-1:0] w_best_cnt;
    logic             w_found;

    always_comb begin
        for (int b = 0; b < NB; b++) begin
            w_cnt[b] = '0;
        end
        for (int b = 0; b < NB; b++) begin
            for (int i = 0; i < WIN; i++) begin
                if (i_vld[i] && (i_bins[i] == LVL_W'(b))) begin
                    w_cnt[b] = w_cnt[b] + CNT_W'(1);
                end
            end
        end
    end

    // Strict greater-than keeps the lowest bin on ties
    always_comb begin
        o_bin      = '0;
        w_best_cnt = w_cnt[0];
        for (int b = 1; b < NB; b++) begin
            if (w_cnt[b] > w_best_cnt) begin
                w_best_cnt = w_cnt[b];
                o_bin      = LVL_W'(b);
            end
        end
    end

    always_comb begin
        o_sel   = '0;
        w_found = 1'b0;
        for (int i = 0; i < WIN; i++) begin
            if (!w_found && i_vld[i] && (i_bins[i] == o_bin)) begin
                o_sel   = IDX_W'(i);
                w_found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/oil_paint_stream.sv
`default_nettype none
// ============================================================================
// Module      : oil_paint_stream
// Description : Streaming oil-painting filter (bypass / quantise / oil per line).
//               Optional Bayer dither: define OIL_PAINT_DITHER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module oil_paint_stream
    import oil_paint_pkg::*;
#(
    parameter int IN_W  = 10,
    parameter int CH_W  = 5,
    parameter int WIN   = 5,
    parameter int LVL_W = 3
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [1:0]      i_mode,
    input  logic            i_sol,
    input  logic            i_valid,
    input  logic [IN_W-1:0] i_red,
    input  logic [IN_W-1:0] i_green,
    input  logic [IN_W-1:0] i_blue,
    output logic            o_valid,
    output logic [IN_W-1:0] o_red,
    output logic [IN_W-1:0] o_green,
    output logic [IN_W-1:0] o_blue
);
    localparam int IDX_W = $clog2(WIN);
    localparam int PAD   = IN_W - CH_W;

    function automatic logic [IN_W-1:0] expand(input logic [CH_W-1:0] q);
        return IN_W'(q) << PAD;
    endfunction

    mode_e           r_mode;
    mode_e           w_mode;
    logic [IN_W-1:0] w_red, w_green, w_blue;

    // Mode in force for the pixel on this edge (a new line loads i_mode)
    assign w_mode = i_sol ? decode_mode(i_mode) : r_mode;

`ifdef OIL_PAINT_DITHER_EN
    logic            r_parity, r_x_lsb;
    logic            w_parity, w_x_lsb, w_dith_en;
    logic [1:0]      w_bayer;
    logic [IN_W-1:0] w_off;

    function automatic logic [IN_W-1:0] sat_add(input logic [IN_W-1:0] c,
                                                input logic [IN_W-1:0] o,
                                                input logic            en);
        logic [IN_W:0] s;
        s = {1'b0, c} + {1'b0, o};
        if (!en) return c;
        return s[IN_W] ? {IN_W{1'b1}} : s[IN_W-1:0];
    endfunction

    assign w_parity  = i_sol ? ~r_parity : r_parity;
    assign w_x_lsb   = i_sol ? 1'b0 : r_x_lsb;
    assign w_bayer   = c_bayer[{w_parity, w_x_lsb}];
    assign w_dith_en = (w_mode != MODE_BYPASS);

    generate
        if (PAD >= 2) begin : g_off_shl
            assign w_off = IN_W'(w_bayer) << (PAD - 2);
        end else begin : g_off_shr
            assign w_off = IN_W'(w_bayer >> (2 - PAD));
        end
    endgenerate

    assign w_red   = sat_add(i_red,   w_off, w_dith_en);
    assign w_green = sat_add(i_green, w_off, w_dith_en);
    assign w_blue  = sat_add(i_blue,  w_off, w_dith_en);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_parity <= 1'b0;
            r_x_lsb  <= 1'b0;
        end else begin
            r_parity <= w_parity;
            r_x_lsb  <= w_x_lsb ^ i_valid;
        end
    end
`else
    assign w_red   = i_red;
    assign w_green = i_green;
    assign w_blue  = i_blue;
`endif

    logic [CH_W-1:0]  w_qr, w_qg, w_qb;
    logic [LVL_W-1:0] w_bin;

    assign w_qr  = w_red  [IN_W-1 -: CH_W];
    assign w_qg  = w_green[IN_W-1 -: CH_W];
    assign w_qb  = w_blue [IN_W-1 -: CH_W];
    assign w_bin = LVL_W'(calc_bin(16'(w_qr), 16'(w_qg), 16'(w_qb), CH_W, LVL_W));

    // Stage 1: capture pixel and shift it into the window (index 0 = newest)
    logic             r_s1_valid;
    logic [IN_W-1:0]  r_raw_red, r_raw_green, r_raw_blue;
    logic [CH_W-1:0]  r_win_qr [WIN];
    logic [CH_W-1:0]  r_win_qg [WIN];
    logic [CH_W-1:0]  r_win_qb [WIN];
    logic [LVL_W-1:0] r_win_bin [WIN];
    logic [WIN-1:0]   r_win_vld;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode      <= MODE_BYPASS;
            r_s1_valid  <= 1'b0;
            r_raw_red   <= '0;
            r_raw_green <= '0;
            r_raw_blue  <= '0;
            r_win_vld   <= '0;
            for (int k = 0; k < WIN; k++) begin
                r_win_qr[k]  <= '0;
                r_win_qg[k]  <= '0;
                r_win_qb[k]  <= '0;
                r_win_bin[k] <= '0;
            end
        end else begin
            r_s1_valid <= i_valid;
            if (i_sol) r_mode <= w_mode;
            if (i_valid) begin
                r_raw_red    <= i_red;
                r_raw_green  <= i_green;
                r_raw_blue   <= i_blue;
                r_win_qr[0]  <= w_qr;
                r_win_qg[0]  <= w_qg;
                r_win_qb[0]  <= w_qb;
                r_win_bin[0] <= w_bin;
                for (int k = 1; k < WIN; k++) begin
                    r_win_qr[k]  <= r_win_qr[k-1];
                    r_win_qg[k]  <= r_win_qg[k-1];
                    r_win_qb[k]  <= r_win_qb[k-1];
                    r_win_bin[k] <= r_win_bin[k-1];
                end
                r_win_vld <= i_sol ? WIN'(1) : {r_win_vld[WIN-2:0], 1'b1};
            end else if (i_sol) begin
                r_win_vld <= '0;
            end
        end
    end

    logic [LVL_W-1:0] w_win_bin;
    logic [IDX_W-1:0] w_sel;
    logic             w_hit;

    oil_paint_hist #(
        .WIN   (WIN),
        .LVL_W (LVL_W)
    ) u_hist (
        .i_bins (r_win_bin),
        .i_vld  (r_win_vld),
        .o_bin  (w_win_bin),
        .o_sel  (w_sel)
    );

    assign w_hit = r_win_vld[w_sel] && (r_win_bin[w_sel] == w_win_bin);

    logic [IN_W-1:0] w_sel_red, w_sel_green, w_sel_blue;

    always_comb begin
        w_sel_red   = r_raw_red;
        w_sel_green = r_raw_green;
        w_sel_blue  = r_raw_blue;
        case (r_mode)
            MODE_QUANT: begin
                w_sel_red   = expand(r_win_qr[0]);
                w_sel_green = expand(r_win_qg[0]);
                w_sel_blue  = expand(r_win_qb[0]);
            end
            MODE_OIL: begin
                w_sel_red   = w_hit ? expand(r_win_qr[w_sel]) : expand(r_win_qr[0]);
                w_sel_green = w_hit ? expand(r_win_qg[w_sel]) : expand(r_win_qg[0]);
                w_sel_blue  = w_hit ? expand(r_win_qb[w_sel]) : expand(r_win_qb[0]);
            end
            default: ;
        endcase
    end

    // Stage 2 holds the selection one cycle, then the output register drives VGA
    logic            r_s2_valid, r_out_valid;
    logic [IN_W-1:0] r_s2_red, r_s2_green, r_s2_blue;
    logic [IN_W-1:0] r_out_red, r_out_green, r_out_blue;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s2_valid  <= 1'b0;
            r_s2_red    <= '0;
            r_s2_green  <= '0;
            r_s2_blue   <= '0;
            r_out_valid <= 1'b0;
            r_out_red   <= '0;
            r_out_green <= '0;
            r_out_blue  <= '0;
        end else begin
            r_s2_valid  <= r_s1_valid;
            r_out_valid <= r_s2_valid;
            if (r_s1_valid) begin
                r_s2_red   <= w_sel_red;
                r_s2_green <= w_sel_green;
                r_s2_blue  <= w_sel_blue;
            end
            if (r_s2_valid) begin
                r_out_red   <= r_s2_red;
                r_out_green <= r_s2_green;
                r_out_blue  <= r_s2_blue;
            end
        end
    end

    assign o_valid = r_out_valid;
    assign o_red   = r_out_red;
    assign o_green = r_out_green;
    assign o_blue  = r_out_blue;

endmodule
`default_nettype wire

// File: tb/tb_oil_paint_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_oil_paint_stream
// Description : Self-checking bench: line-window reference model plus literal
//               expectations for the directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oil_paint_stream;
    localparam int IN_W  = 10;
    localparam int CH_W  = 5;
    localparam int WIN   = 5;
    localparam int LVL_W = 3;
    localparam int SH    = IN_W - CH_W;
    localparam int NBIN  = 2 ** LVL_W;
    localparam int DEPTH = 512;

    logic            i_clk   = 1'b0;
    logic            i_rst_n = 1'b0;
    logic [1:0]      i_mode  = 2'd0;
    logic            i_sol   = 1'b0;
    logic            i_valid = 1'b0;
    logic [IN_W-1:0] i_red   = '0;
    logic [IN_W-1:0] i_green = '0;
    logic [IN_W-1:0] i_blue  = '0;
    logic            o_valid;
    logic [IN_W-1:0] o_red, o_green, o_blue;

    oil_paint_stream #(
        .IN_W (IN_W), .CH_W (CH_W), .WIN (WIN), .LVL_W (LVL_W)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_mode  (i_mode),
        .i_sol   (i_sol),
        .i_valid (i_valid),
        .i_red   (i_red),
        .i_green (i_green),
        .i_blue  (i_blue),
        .o_valid (o_valid),
        .o_red   (o_red),
        .o_green (o_green),
        .o_blue  (o_blue)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Expected activity per clock-edge index
    bit              exp_v   [DEPTH];
    bit              exp_rst [DEPTH];
    logic [IN_W-1:0] exp_r [DEPTH], exp_g [DEPTH], exp_b [DEPTH];
    bit              lit_v   [DEPTH];
    logic [IN_W-1:0] lit_r [DEPTH], lit_g [DEPTH], lit_b [DEPTH];

    int checks = 0;
    int errors = 0;
    logic [IN_W-1:0] hr = '0, hg = '0, hb = '0;

    always @(negedge i_clk) begin
        if (cyc > 0 && cyc < DEPTH) begin
            if (exp_rst[cyc]) begin
                hr = '0; hg = '0; hb = '0;
            end
            if (exp_v[cyc]) begin
                hr = exp_r[cyc]; hg = exp_g[cyc]; hb = exp_b[cyc];
            end
            checks++;
            if (o_valid !== exp_v[cyc] || o_red !== hr || o_green !== hg || o_blue !== hb) begin
                errors++;
                $display("FAIL model cyc=%0d: got v=%0b rgb=%03h/%03h/%03h, expected v=%0b rgb=%03h/%03h/%03h",
                         cyc, o_valid, o_red, o_green, o_blue, exp_v[cyc], hr, hg, hb);
            end
            if (lit_v[cyc]) begin
                checks++;
                if (o_valid !== 1'b1 || o_red !== lit_r[cyc] || o_green !== lit_g[cyc] || o_blue !== lit_b[cyc]) begin
                    errors++;
                    $display("FAIL literal cyc=%0d: got v=%0b rgb=%03h/%03h/%03h, expected v=1 rgb=%03h/%03h/%03h",
                             cyc, o_valid, o_red, o_green, o_blue, lit_r[cyc], lit_g[cyc], lit_b[cyc]);
                end
            end
        end
    end

    // Reference model: the current line as a list of (quantised colour, bin)
    typedef struct {
        int r;
        int g;
        int b;
        int bin;
    } ent_t;

    ent_t line_q[$];
    int   m_mode = 0;

    task automatic step(input bit sol, input logic [1:0] mode, input bit v,
                        input logic [IN_W-1:0] r, input logic [IN_W-1:0] g,
                        input logic [IN_W-1:0] b, input bit chk,
                        input logic [IN_W-1:0] er, input logic [IN_W-1:0] eg,
                        input logic [IN_W-1:0] eb);
        ent_t e;
        int   cnt [NBIN];
        int   best, sel, idx;
        bit   found;
        i_sol = sol; i_mode = mode; i_valid = v;
        i_red = r; i_green = g; i_blue = b;
        if (sol) begin
            m_mode = (mode == 2'd0) ? 0 : (mode == 2'd1) ? 1 : 2;
            line_q.delete();
        end
        if (v) begin
            e.r = int'(r) >> SH;
            e.g = int'(g) >> SH;
            e.b = int'(b) >> SH;
            e.bin = (e.r + 2 * e.g + e.b) >> (CH_W + 2 - LVL_W);
            line_q.push_front(e);
            if (line_q.size() > WIN) void'(line_q.pop_back());
            idx = cyc + 3;
            exp_v[idx] = 1'b1;
            if (m_mode == 0) begin
                exp_r[idx] = r; exp_g[idx] = g; exp_b[idx] = b;
            end else if (m_mode == 1) begin
                exp_r[idx] = IN_W'(e.r << SH); exp_g[idx] = IN_W'(e.g << SH); exp_b[idx] = IN_W'(e.b << SH);
            end else begin
                foreach (cnt[k]) cnt[k] = 0;
                foreach (line_q[i]) cnt[line_q[i].bin]++;
                best = 0;
                for (int k = 1; k < NBIN; k++) if (cnt[k] > cnt[best]) best = k;
                sel = 0; found = 1'b0;
                for (int i = 0; i < line_q.size(); i++) begin
                    if (!found && line_q[i].bin == best) begin
                        sel = i; found = 1'b1;
                    end
                end
                exp_r[idx] = IN_W'(line_q[sel].r << SH);
                exp_g[idx] = IN_W'(line_q[sel].g << SH);
                exp_b[idx] = IN_W'(line_q[sel].b << SH);
            end
            if (chk) begin
                lit_v[idx] = 1'b1; lit_r[idx] = er; lit_g[idx] = eg; lit_b[idx] = eb;
            end
        end
        @(posedge i_clk); #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            i_sol = 1'b0; i_valid = 1'b0;
            @(posedge i_clk); #1;
        end
    endtask

    task automatic pulse_reset();
        i_sol = 1'b0; i_valid = 1'b0;
        i_rst_n = 1'b0;
        for (int k = cyc; k < DEPTH; k++) begin
            exp_v[k] = 1'b0; lit_v[k] = 1'b0;
        end
        exp_rst[cyc] = 1'b1;
        m_mode = 0;
        line_q.delete();
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
    endtask

    localparam logic [IN_W-1:0] WH = 10'h3FF;
    localparam logic [IN_W-1:0] BK = 10'h000;

    logic [IN_W-1:0] pal_r [6] = '{10'h3FF, 10'h000, 10'h155, 10'h200, 10'h3E0, 10'h0A0};
    logic [IN_W-1:0] pal_g [6] = '{10'h3FF, 10'h000, 10'h2AA, 10'h100, 10'h000, 10'h140};
    logic [IN_W-1:0] pal_b [6] = '{10'h3FF, 10'h000, 10'h3FF, 10'h080, 10'h3E0, 10'h0A0};
    int seq [12] = '{2, 2, 0, 3, 3, 2, 1, 0, 0, 5, 4, 3};

    initial begin
        repeat (3) @(posedge i_clk);
        #1 i_rst_n = 1'b1;

        // bypass
        step(1, 2'd0, 1, 10'h155, 10'h2AA, 10'h3FF, 1, 10'h155, 10'h2AA, 10'h3FF);
        idle(3);
        // quantise
        step(1, 2'd1, 1, 10'h3FF, 10'h21F, 10'h01F, 1, 10'h3E0, 10'h200, 10'h000);
        idle(2);
        // oil W,B,B,W,W with a 2:2 tie on the 4th pixel
        step(1, 2'd2, 1, WH, WH, WH, 1, 10'h3E0, 10'h3E0, 10'h3E0);
        step(0, 2'd2, 1, BK, BK, BK, 1, BK, BK, BK);
        step(0, 2'd2, 1, BK, BK, BK, 1, BK, BK, BK);
        step(0, 2'd2, 1, WH, WH, WH, 1, BK, BK, BK);
        step(0, 2'd2, 1, WH, WH, WH, 1, 10'h3E0, 10'h3E0, 10'h3E0);
        idle(2);
        // window cleared on line start
        step(1, 2'd2, 1, WH, WH, WH, 0, BK, BK, BK);
        for (int k = 0; k < 4; k++) step(0, 2'd2, 1, WH, WH, WH, 0, BK, BK, BK);
        step(1, 2'd2, 1, BK, BK, BK, 1, BK, BK, BK);
        idle(2);
        // mode change without line start is ignored
        step(1, 2'd2, 1, 10'h155, 10'h2AA, 10'h3FF, 1, 10'h140, 10'h2A0, 10'h3E0);
        step(0, 2'd0, 1, 10'h155, 10'h2AA, 10'h3FF, 1, 10'h140, 10'h2A0, 10'h3E0);
        step(1, 2'd0, 1, 10'h155, 10'h2AA, 10'h3FF, 1, 10'h155, 10'h2AA, 10'h3FF);
        step(0, 2'd2, 1, 10'h155, 10'h2AA, 10'h3FF, 1, 10'h155, 10'h2AA, 10'h3FF);
        step(1, 2'd3, 1, WH, WH, WH, 1, 10'h3E0, 10'h3E0, 10'h3E0);
        idle(2);
        // mixed oil line with one gap cycle
        for (int i = 0; i < 12; i++) begin
            step(i == 0, 2'd2, i != 5, pal_r[seq[i]], pal_g[seq[i]], pal_b[seq[i]], 0, BK, BK, BK);
        end
        idle(3);
        // reset with two pixels in flight
        step(1, 2'd2, 1, 10'h155, 10'h2AA, 10'h3FF, 0, BK, BK, BK);
        step(0, 2'd2, 1, WH, WH, WH, 0, BK, BK, BK);
        pulse_reset();
        idle(3);
        step(0, 2'd2, 1, 10'h155, 10'h2AA, 10'h3FF, 1, 10'h155, 10'h2AA, 10'h3FF);
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
